// File: rtl/mips_cpu_prefetch.sv
// mips_cpu_prefetch: Avalon-MM instruction prefetch buffer with redirect and halt-on-pc-0.
// Ports:
//   clk, reset (async, active-low), clk_enable (0 = hold everything).
//   avm_address/avm_read/avm_waitrequest/avm_readdata: instruction fetch master.
//   instr_valid/instr_data/instr_pc/instr_ready: head of the buffer to the core.
//   redirect/redirect_pc: flush and refetch. active: low once halted.
//   stall_count: starvation counter, present only with MIPS_PREFETCH_STALL_COUNTER_EN.
module mips_cpu_prefetch #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  output logic [31:0]           avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [DATA_WIDTH-1:0] avm_readdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [31:0]           instr_pc,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  active,
  output logic [31:0]           stall_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    FETCH,
    DISCARD,
    HALTED
  } state_t;

  state_t          state, state_n;
  logic [31:0]     fetch_pc, fetch_pc_n;
  logic [31:0]     tgt, tgt_n;
  logic [31:0]     addr_n;
  logic            rd_n;
  logic [CW-1:0]   count, cnt_n;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            flush, push, do_pop;

  logic [31:0]           mem_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];

  logic        stalled, done, pop, halt_pop;
  logic [31:0] rpc;

  assign rpc      = redirect_pc & 32'hFFFF_FFFC;
  assign stalled  = avm_read & avm_waitrequest;
  assign done     = avm_read & ~avm_waitrequest;

  assign instr_valid = (count != '0) && (state == FETCH);
  assign instr_pc    = mem_pc[rd_ptr];
  assign instr_data  = mem_data[rd_ptr];
  assign active      = (state != HALTED);

  assign pop      = instr_valid & instr_ready;
  assign halt_pop = pop && (instr_pc == 32'h0);

  always_comb begin
    state_n    = state;
    rd_n       = avm_read;
    addr_n     = avm_address;
    fetch_pc_n = fetch_pc;
    tgt_n      = tgt;
    cnt_n      = count;
    flush      = 1'b0;
    push       = 1'b0;
    do_pop     = 1'b0;
    unique case (state)
      FETCH: begin
        if (redirect) begin
          flush = 1'b1;
          cnt_n = '0;
          if (stalled) begin
            // Bus must stay stable; swallow the stale beat later.
            state_n = DISCARD;
            tgt_n   = rpc;
          end else begin
            rd_n       = 1'b1;
            addr_n     = rpc;
            fetch_pc_n = rpc + 32'd4;
          end
        end else if (halt_pop) begin
          state_n = HALTED;
          flush   = 1'b1;
          cnt_n   = '0;
          rd_n    = stalled;
        end else begin
          push   = done;
          do_pop = pop;
          cnt_n  = count + CW'(push) - CW'(do_pop);
          if (!stalled) begin
            // No read in flight after this edge, so cnt_n alone bounds space.
            if (cnt_n < CW'(DEPTH)) begin
              rd_n       = 1'b1;
              addr_n     = fetch_pc;
              fetch_pc_n = fetch_pc + 32'd4;
            end else begin
              rd_n = 1'b0;
            end
          end
        end
      end
      DISCARD: begin
        if (redirect) tgt_n = rpc;
        if (done) begin
          state_n    = FETCH;
          rd_n       = 1'b1;
          addr_n     = redirect ? rpc : tgt;
          fetch_pc_n = addr_n + 32'd4;
        end
      end
      HALTED: begin
        rd_n = stalled;
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      avm_read    <= 1'b0;
      avm_address <= RESET_VECTOR;
      fetch_pc    <= RESET_VECTOR;
      tgt         <= RESET_VECTOR;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (clk_enable) begin
      state       <= state_n;
      avm_read    <= rd_n;
      avm_address <= addr_n;
      fetch_pc    <= fetch_pc_n;
      tgt         <= tgt_n;
      count       <= cnt_n;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + PW'(1);
        if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk_enable && push) begin
      mem_pc[wr_ptr]   <= avm_address;
      mem_data[wr_ptr] <= avm_readdata;
    end
  end

`ifdef MIPS_PREFETCH_STALL_COUNTER_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (clk_enable && active && instr_ready && !instr_valid) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 32'h0;
`endif

endmodule
